sparse_tb_builder: RTL and testbench

Self-contained sparse-intersection test harness for the sparse memory-core regression. A host loads two sorted coordinate lists and their lengths through a 32-bit config write port. The host then releases flush and stall, and the block merge-intersects the lists at one comparison per active cycle. It raises `done` and reports the number of comparison steps on `cycle_count`, so the bench can end the test and log performance.

---
 rtl/sparse_tb_builder_pkg.sv | 19 +
 rtl/sparse_tb_builder_if.sv | 24 ++
 rtl/sparse_tb_builder_coord_bank.sv | 28 ++
 rtl/sparse_tb_builder.sv | 144 ++++++++++++++
 tb/tb_sparse_tb_builder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparse_tb_builder_pkg.sv
// Shared types and constants for the sparse-intersection test harness.
`timescale 1ns/1ps
package sparse_tb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [31:0] LEN_A  = 32'h000;
  localparam logic [31:0] LEN_B  = 32'h004;
  localparam logic [31:0] A_BASE = 32'h100;
  localparam logic [31:0] B_BASE = 32'h200;

  localparam int unsigned DEFAULT_DEPTH   = 64;
  localparam int unsigned DEFAULT_COORD_W = 16;

endpackage

// File: rtl/sparse_tb_builder_if.sv
// Host-side 32-bit configuration bus of the sparse-intersection harness.
`timescale 1ns/1ps
interface sparse_tb_builder_if;

  logic [31:0] config_config_addr;
  logic [31:0] config_config_data;
  logic        config_read;
  logic        config_write;

  modport master (
    output config_config_addr,
    output config_config_data,
    output config_read,
    output config_write
  );

  modport slave (
    input config_config_addr,
    input config_config_data,
    input config_read,
    input config_write
  );

endinterface

// File: rtl/sparse_tb_builder_coord_bank.sv
// DEPTH x COORD_W coordinate register file: synchronous write, asynchronous read, no reset.
`timescale 1ns/1ps
module coord_bank
  import sparse_tb_pkg::*;
#(
  parameter  int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter  int unsigned COORD_W = DEFAULT_COORD_W,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [COORD_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [COORD_W-1:0] rdata
);

  logic [COORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sparse_tb_builder.sv
// Sparse-intersection harness: config decoder, LEN registers, merge FSM and step counter.
`timescale 1ns/1ps
module sparse_tb_builder
  import sparse_tb_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned COORD_W = DEFAULT_COORD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  sparse_tb_builder_if.slave  cfg,
  output logic                done,
  output logic [63:0]         cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  state_e        state_q, state_d;
  logic [PW-1:0] i_q, i_d, j_q, j_d;
  logic [PW-1:0] len_a_q, len_a_d, len_b_q, len_b_d;
  logic [63:0]   cnt_q, cnt_d;
  logic          done_q, done_d;

  logic          cfg_we, a_we, b_we;
  logic [31:0]   a_off, b_off;
  logic [PW-1:0] len_sat;
  logic [COORD_W-1:0] a_rd, b_rd;
  logic          unused_cfg;

  assign unused_cfg = ^{cfg.config_read, cfg.config_config_data[31:COORD_W]};

  // Offsets wrap below the base, so one unsigned compare bounds both ends.
  assign a_off  = cfg.config_config_addr - A_BASE;
  assign b_off  = cfg.config_config_addr - B_BASE;
  assign cfg_we = cfg.config_write && (state_q != RUN);
  assign a_we   = cfg_we && (cfg.config_config_addr[1:0] == 2'b00) && (a_off < SPAN);
  assign b_we   = cfg_we && (cfg.config_config_addr[1:0] == 2'b00) && (b_off < SPAN);

  always_comb begin
    len_sat = PW'(DEPTH);
    if (cfg.config_config_data[8:0] <= 9'(DEPTH)) begin
      len_sat = PW'(cfg.config_config_data[8:0]);
    end
  end

  always_comb begin
    len_a_d = len_a_q;
    len_b_d = len_b_q;
    if (cfg_we && cfg.config_config_addr == LEN_A) len_a_d = len_sat;
    if (cfg_we && cfg.config_config_addr == LEN_B) len_b_d = len_sat;
  end

  always_ff @(posedge clk) begin
    len_a_q <= len_a_d;
    len_b_q <= len_b_d;
  end

  coord_bank #(.DEPTH(DEPTH), .COORD_W(COORD_W)) u_bank_a (
    .clk   (clk),
    .we    (a_we),
    .waddr (a_off[AW+1:2]),
    .wdata (cfg.config_config_data[COORD_W-1:0]),
    .raddr (i_q[AW-1:0]),
    .rdata (a_rd)
  );

  coord_bank #(.DEPTH(DEPTH), .COORD_W(COORD_W)) u_bank_b (
    .clk   (clk),
    .we    (b_we),
    .waddr (b_off[AW+1:2]),
    .wdata (cfg.config_config_data[COORD_W-1:0]),
    .raddr (j_q[AW-1:0]),
    .rdata (b_rd)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (flush) begin
      state_d = IDLE;
      i_d     = '0;
      j_d     = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          i_d    = '0;
          j_d    = '0;
          cnt_d  = '0;
          done_d = 1'b0;
          if (!stall) state_d = RUN;
        end
        RUN: begin
          if (!stall) begin
            if (i_q == len_a_q || j_q == len_b_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 64'd1;
              if (a_rd == b_rd) begin
                i_d = i_q + 1'b1;
                j_d = j_q + 1'b1;
              end else if (a_rd < b_rd) begin
                i_d = i_q + 1'b1;
              end else begin
                j_d = j_q + 1'b1;
              end
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign done        = done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_sparse_tb_builder.sv
// Randomized and directed bench for sparse_tb_builder against a list-level merge model.
`timescale 1ns/1ps
module tb_sparse_tb_builder;

  localparam int DEPTH = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b1;
  logic        flush = 1'b0;
  logic        done;
  logic [63:0] cycle_count;

  sparse_tb_builder_if cfg_if();

  sparse_tb_builder #(.DEPTH(DEPTH), .COORD_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .cfg         (cfg_if),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int unsigned m_a [DEPTH];
  int unsigned m_b [DEPTH];
  int unsigned m_la = 0, m_lb = 0;
  int          m_state = 0;   // 0 idle, 1 running, 2 finished
  int unsigned m_k = 0, m_s = 0;

  function automatic int unsigned model_steps();
    int unsigned i = 0, j = 0, s = 0;
    while (i < m_la && j < m_lb) begin
      if (m_a[i] == m_b[j]) begin i++; j++; end
      else if (m_a[i] < m_b[j]) i++;
      else j++;
      s++;
    end
    return s;
  endfunction

  function automatic void model_write(logic [31:0] addr, logic [31:0] data);
    int unsigned raw;
    raw = int'(data[8:0]);
    if (raw > DEPTH) raw = DEPTH;
    if (addr == 32'h0) m_la = raw;
    else if (addr == 32'h4) m_lb = raw;
    else if (addr[1:0] == 2'b00 && addr >= 32'h100 && addr < 32'h100 + 4*DEPTH)
      m_a[(addr - 32'h100) >> 2] = int'(data[15:0]);
    else if (addr[1:0] == 2'b00 && addr >= 32'h200 && addr < 32'h200 + 4*DEPTH)
      m_b[(addr - 32'h200) >> 2] = int'(data[15:0]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_k     = 0;
    end else begin
      if (cfg_if.config_write && m_state != 1)
        model_write(cfg_if.config_config_addr, cfg_if.config_config_data);
      if (flush) begin
        m_state = 0;
        m_k     = 0;
      end else if (m_state == 0) begin
        if (!stall) begin
          m_state = 1;
          m_k     = 0;
          m_s     = model_steps();
        end
      end else if (m_state == 1 && !stall) begin
        if (m_k == m_s) m_state = 2;
        else m_k++;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_done", {63'd0, done}, (m_state == 2) ? 64'd1 : 64'd0);
    chk("model_count", cycle_count, (m_state == 0) ? 64'd0 : 64'(m_k));
  end

  // ---------------- stimulus helpers ----------------
  int unsigned ta [DEPTH];
  int unsigned tb [DEPTH];

  task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] data);
    cfg_if.config_config_addr = addr;
    cfg_if.config_config_data = data;
    cfg_if.config_read        = 1'($urandom_range(0, 1));
    cfg_if.config_write       = 1'b1;
    @(negedge clk);
    cfg_if.config_write       = 1'b0;
  endtask

  task automatic load(input int unsigned la_raw, input int unsigned lb_raw);
    int unsigned la, lb;
    la = (la_raw > DEPTH) ? DEPTH : la_raw;
    lb = (lb_raw > DEPTH) ? DEPTH : lb_raw;
    cfg_wr(32'h0, la_raw);
    cfg_wr(32'h4, lb_raw);
    for (int unsigned k = 0; k < la; k++) cfg_wr(32'h100 + 4*k, ta[k]);
    for (int unsigned k = 0; k < lb; k++) cfg_wr(32'h200 + 4*k, tb[k]);
  endtask

  // Starts from a negedge with stall=1; returns edges from RUN entry to done.
  task automatic run(input int stall_at, input int stall_len, input bit rnd_stall,
                     input bit wr_mid, input bit entry_wr,
                     input logic [31:0] e_addr, input logic [31:0] e_data,
                     input int flush_at, input int rst_at, output int lat);
    int n;
    bit was_reset;
    stall = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    if (entry_wr) begin
      cfg_if.config_config_addr = e_addr;
      cfg_if.config_config_data = e_data;
      cfg_if.config_write       = 1'b1;
    end
    lat = -1;
    n = 0;
    was_reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n++;
      cfg_if.config_write = 1'b0;
      if (done) begin
        lat = n - 1;
        break;
      end
      if (rnd_stall) stall = ($urandom_range(0, 3) == 0);
      else if (n == stall_at + 1) stall = 1'b1;
      else if (n == stall_at + 1 + stall_len) stall = 1'b0;
      if (wr_mid && n == 2) begin
        cfg_if.config_config_addr = ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h0;
        cfg_if.config_config_data = 32'd999;
        cfg_if.config_write       = 1'b1;
      end
      flush = (n == flush_at);
      if (n == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_done", {63'd0, done}, 64'd0);
        chk("async_reset_count", cycle_count, 64'd0);
        stall = 1'b1;
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        was_reset = 1'b1;
        break;
      end
    end
    if (!was_reset && lat < 0) chk("done_timeout", 64'd0, 64'd1);
    stall = 1'b1;
    flush = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int lat;

  initial begin
    cfg_if.config_config_addr = '0;
    cfg_if.config_config_data = '0;
    cfg_if.config_read        = 1'b0;
    cfg_if.config_write       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_count", cycle_count, 64'd0);

    // basic intersection
    ta[0] = 1; ta[1] = 3; ta[2] = 5; ta[3] = 7;
    tb[0] = 3; tb[1] = 4; tb[2] = 7;
    load(4, 3);
    run(-10, 0, 0, 0, 0, '0, '0, -1, -1, lat);
    chk("basic_count", cycle_count, 64'd5);
    chk("basic_latency", 64'(lat), 64'd6);
    chk("basic_done", {63'd0, done}, 64'd1);

    // 10-cycle stall after the second step
    run(2, 10, 0, 0, 0, '0, '0, -1, -1, lat);
    chk("stall_count", cycle_count, 64'd5);
    chk("stall_latency", 64'(lat), 64'd16);

    // empty A
    cfg_wr(32'h0, 0);
    cfg_wr(32'h4, 5);
    run(-10, 0, 0, 0, 0, '0, '0, -1, -1, lat);
    chk("empty_count", cycle_count, 64'd0);
    chk("empty_latency", 64'(lat), 64'd1);

    // LEN_A written on the IDLE->RUN edge still takes effect
    cfg_wr(32'h4, 3);
    run(-10, 0, 0, 0, 1, 32'h0, 32'd4, -1, -1, lat);
    chk("entry_write_count", cycle_count, 64'd5);
    chk("entry_write_latency", 64'(lat), 64'd6);

    // full banks, disjoint; LEN_A saturates from 300
    for (int k = 0; k < DEPTH; k++) begin
      ta[k] = 2*k;
      tb[k] = 2*k + 1;
    end
    load(300, 64);
    run(-10, 0, 0, 0, 0, '0, '0, -1, -1, lat);
    chk("full_count", cycle_count, 64'd127);
    chk("full_latency", 64'(lat), 64'd128);

    // flush after done clears on the next edge
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done", {63'd0, done}, 64'd0);
    chk("flush_count", cycle_count, 64'd0);

    // rerun with a write attempted during RUN
    run(-10, 0, 0, 1, 0, '0, '0, -1, -1, lat);
    chk("rerun_count", cycle_count, 64'd127);

    // async reset mid-run, config retained
    run(-10, 0, 0, 0, 0, '0, '0, -1, 5, lat);
    run(-10, 0, 0, 0, 0, '0, '0, -1, -1, lat);
    chk("post_reset_count", cycle_count, 64'd127);

    // flush mid-run restarts the engine
    run(-10, 0, 0, 0, 0, '0, '0, 4, -1, lat);
    chk("flush_restart_count", cycle_count, 64'd127);

    // randomized lists, lengths, stalls and dropped writes
    for (int it = 0; it < 12; it++) begin
      int unsigned la, lb;
      la = $urandom_range(0, 70);
      lb = $urandom_range(0, 70);
      ta[0] = $urandom_range(0, 3);
      tb[0] = $urandom_range(0, 3);
      for (int k = 1; k < DEPTH; k++) begin
        ta[k] = ta[k-1] + $urandom_range(1, 4);
        tb[k] = tb[k-1] + $urandom_range(1, 4);
      end
      if (it % 4 == 3) begin
        for (int k = 0; k < DEPTH; k++) begin
          ta[k] = $urandom_range(0, 15);
          tb[k] = $urandom_range(0, 15);
        end
      end
      load(la, lb);
      run(-10, 0, 1, (it % 2 == 1), 0, '0, '0, -1, -1, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
